// File: rtl/vx_lock_rr_arbiter.sv
// Round-robin arbiter with grant locking: one requester keeps the shared resource
// until the downstream side reports consumption on grant_unlock.

module VX_onehot_encoder #(
    parameter int N  = 4,
    parameter int LN = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  data_in,
    output logic [LN-1:0] data_out,
    output logic          valid_out
);
    // OR of the indices of all set bits; exact for a one-hot (or zero) input.
    always_comb begin
        data_out = '0;
        for (int i = 0; i < N; i++) begin
            if (data_in[i]) begin
                data_out = data_out | LN'(i);
            end
        end
    end

    assign valid_out = |data_in;
endmodule

// Handshake: grant_valid/grant_onehot/grant_index describe the current owner; the
// downstream side pulses grant_unlock in the cycle it consumes the grant. A locked owner
// must keep its request bit high until that cycle; grant_unlock never affects the
// current-cycle grant, only the next state.
module vx_lock_rr_arbiter #(
    parameter int NUM_REQS     = 4,
    parameter int LOCK_ENABLE  = 1,
    parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQS-1:0]     requests,
    input  logic                    grant_unlock,
    output logic                    grant_valid,
    output logic [NUM_REQS-1:0]     grant_onehot,
    output logic [LOG_NUM_REQS-1:0] grant_index,
    output logic                    debug_locked,
    output logic [LOG_NUM_REQS-1:0] debug_prio_ptr
);
    logic [LOG_NUM_REQS-1:0] prio_ptr;
    logic                    locked;
    logic [NUM_REQS-1:0]     lock_onehot;
    logic [NUM_REQS-1:0]     masked_reqs;
    logic [NUM_REQS-1:0]     search_reqs;
    logic [NUM_REQS-1:0]     rr_onehot;
    logic                    enc_valid;

    // Requesters after the pointer win first; if none, wrap to the lowest requester.
    always_comb begin
        masked_reqs = '0;
        for (int j = 0; j < NUM_REQS; j++) begin
            masked_reqs[j] = requests[j] && (LOG_NUM_REQS'(j) > prio_ptr);
        end
        search_reqs = (|masked_reqs) ? masked_reqs : requests;
        rr_onehot = '0;
        for (int j = NUM_REQS - 1; j >= 0; j--) begin
            if (search_reqs[j]) begin
                rr_onehot    = '0;
                rr_onehot[j] = 1'b1;
            end
        end
    end

    assign grant_onehot = locked ? lock_onehot : rr_onehot;
    assign grant_valid  = locked | (|requests);

    VX_onehot_encoder #(
        .N  (NUM_REQS),
        .LN (LOG_NUM_REQS)
    ) onehot_encoder (
        .data_in   (grant_onehot),
        .data_out  (grant_index),
        .valid_out (enc_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_ptr    <= LOG_NUM_REQS'(NUM_REQS - 1);
            locked      <= 1'b0;
            lock_onehot <= '0;
        end else begin
            if (grant_valid && grant_unlock) begin
                prio_ptr <= grant_index;
            end
            if (LOCK_ENABLE != 0) begin
                if (locked) begin
                    if (grant_unlock) begin
                        locked <= 1'b0;
                    end
                end else if (grant_valid && !grant_unlock) begin
                    locked      <= 1'b1;
                    lock_onehot <= grant_onehot;
                end
            end
        end
    end

    assign debug_locked   = locked;
    assign debug_prio_ptr = prio_ptr;

`ifndef SYNTHESIS
    logic unused_enc_valid;
    assign unused_enc_valid = enc_valid;

    a_locked_request_held : assert property (
        @(posedge clk) disable iff (reset) locked |-> |(requests & lock_onehot)
    ) else $error("vx_lock_rr_arbiter: locked requester dropped its request");
`endif
endmodule

// File: tb/tb_vx_lock_rr_arbiter.sv
// Directed bench for vx_lock_rr_arbiter: a vector table for the 4-requester locking
// arbiter plus short sequences for 3 requesters, no locking, and a single requester.

module tb_vx_lock_rr_arbiter;
    logic clk;
    logic reset;

    // 4 requesters, locking
    logic [3:0] req4;
    logic       unl4;
    logic       gv4;
    logic [3:0] oh4;
    logic [1:0] idx4;
    logic       lck4;
    logic [1:0] ptr4;

    // 3 requesters, locking
    logic [2:0] req3;
    logic       unl3;
    logic       gv3;
    logic [2:0] oh3;
    logic [1:0] idx3;
    logic       lck3;
    logic [1:0] ptr3;

    // 4 requesters, no locking
    logic [3:0] reqn;
    logic       unln;
    logic       gvn;
    logic [3:0] ohn;
    logic [1:0] idxn;
    logic       lckn;
    logic [1:0] ptrn;

    // single requester
    logic [0:0] req1;
    logic       unl1;
    logic       gv1;
    logic [0:0] oh1;
    logic [0:0] idx1;
    logic       lck1;
    logic [0:0] ptr1;

    int checks;
    int errors;

    vx_lock_rr_arbiter #(.NUM_REQS(4), .LOCK_ENABLE(1)) dut4 (
        .clk(clk), .reset(reset), .requests(req4), .grant_unlock(unl4),
        .grant_valid(gv4), .grant_onehot(oh4), .grant_index(idx4),
        .debug_locked(lck4), .debug_prio_ptr(ptr4)
    );

    vx_lock_rr_arbiter #(.NUM_REQS(3), .LOCK_ENABLE(1)) dut3 (
        .clk(clk), .reset(reset), .requests(req3), .grant_unlock(unl3),
        .grant_valid(gv3), .grant_onehot(oh3), .grant_index(idx3),
        .debug_locked(lck3), .debug_prio_ptr(ptr3)
    );

    vx_lock_rr_arbiter #(.NUM_REQS(4), .LOCK_ENABLE(0)) dutn (
        .clk(clk), .reset(reset), .requests(reqn), .grant_unlock(unln),
        .grant_valid(gvn), .grant_onehot(ohn), .grant_index(idxn),
        .debug_locked(lckn), .debug_prio_ptr(ptrn)
    );

    vx_lock_rr_arbiter #(.NUM_REQS(1), .LOCK_ENABLE(1)) dut1 (
        .clk(clk), .reset(reset), .requests(req1), .grant_unlock(unl1),
        .grant_valid(gv1), .grant_onehot(oh1), .grant_index(idx1),
        .debug_locked(lck1), .debug_prio_ptr(ptr1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       unl;
        logic       valid;
        logic [3:0] oh;
        logic [1:0] idx;
        logic       lck;
        logic [1:0] ptr;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input int step, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    // inputs change on the falling edge; outputs are checked 1ns later
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        next_cycle();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        req4 = '0; unl4 = 1'b0;
        req3 = '0; unl3 = 1'b0;
        reqn = '0; unln = 1'b0;
        req1 = '0; unl1 = 1'b0;

        //          rst  req      unl   valid oh       idx   lck   ptr
        vecs[0]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 2'd3};
        vecs[1]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0, 2'd0};
        vecs[2]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0, 2'd1};
        vecs[3]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b0, 2'd2};
        vecs[4]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 2'd3};
        vecs[5]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0, 2'd0};
        vecs[6]  = '{1'b0, 4'b1010, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b0, 2'd1};
        vecs[7]  = '{1'b0, 4'b1010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0, 2'd3};
        vecs[8]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd1};
        vecs[9]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd1};
        vecs[10] = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd1};
        vecs[11] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd1};
        vecs[12] = '{1'b0, 4'b1111, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b0, 2'd3};
        vecs[13] = '{1'b0, 4'b1111, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 2'd3};
        vecs[14] = '{1'b0, 4'b1111, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 2'd3};
        vecs[15] = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 2'd3};
        vecs[16] = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0, 2'd0};
        vecs[17] = '{1'b0, 4'b1100, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b0, 2'd1};
        vecs[18] = '{1'b0, 4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 2'd1};
        vecs[19] = '{1'b1, 4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 2'd1};
        vecs[20] = '{1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0, 2'd3};
        vecs[21] = '{1'b0, 4'b0001, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b0, 2'd2};
        vecs[22] = '{1'b1, 4'b0001, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 2'd2};
        vecs[23] = '{1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 2'd3};

        do_reset();

        // reset state with no requests
        #1;
        check("rst_valid", 0, 32'(gv4), 32'd0);
        check("rst_onehot", 0, 32'(oh4), 32'd0);
        check("rst_index", 0, 32'(idx4), 32'd0);
        check("rst_locked", 0, 32'(lck4), 32'd0);
        check("rst_ptr", 0, 32'(ptr4), 32'd3);

        // vector table, one row per cycle
        for (int i = 0; i < 24; i++) begin
            next_cycle();
            reset = vecs[i].rst;
            req4  = vecs[i].req;
            unl4  = vecs[i].unl;
            #1;
            check("t4_valid", i, 32'(gv4), 32'(vecs[i].valid));
            check("t4_onehot", i, 32'(oh4), 32'(vecs[i].oh));
            check("t4_index", i, 32'(idx4), 32'(vecs[i].idx));
            check("t4_locked", i, 32'(lck4), 32'(vecs[i].lck));
            check("t4_ptr", i, 32'(ptr4), 32'(vecs[i].ptr));
        end
        next_cycle();
        reset = 1'b0;
        req4  = '0;
        unl4  = 1'b0;

        do_reset();

        // three requesters, requests=101 with unlock: 0,2,0,2
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            req3 = 3'b101;
            unl3 = 1'b1;
            #1;
            check("n3_valid", i, 32'(gv3), 32'd1);
            check("n3_index", i, 32'(idx3), (i % 2 == 0) ? 32'd0 : 32'd2);
            check("n3_onehot", i, 32'(oh3), (i % 2 == 0) ? 32'b001 : 32'b100);
            check("n3_index_range", i, 32'(idx3 < 2'd3), 32'd1);
        end
        next_cycle();
        req3 = '0;
        unl3 = 1'b0;

        // no locking: without unlock the pointer stays put
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            reqn = 4'b0011;
            unln = 1'b0;
            #1;
            check("nl_onehot", i, 32'(ohn), 32'b0001);
            check("nl_index", i, 32'(idxn), 32'd0);
            check("nl_locked", i, 32'(lckn), 32'd0);
            check("nl_ptr", i, 32'(ptrn), 32'd3);
        end
        next_cycle();
        unln = 1'b1;
        #1;
        check("nl_unlock_onehot", 0, 32'(ohn), 32'b0001);
        next_cycle();
        #1;
        check("nl_next_onehot", 0, 32'(ohn), 32'b0010);
        check("nl_next_index", 0, 32'(idxn), 32'd1);
        check("nl_next_ptr", 0, 32'(ptrn), 32'd0);
        next_cycle();
        reqn = '0;
        unln = 1'b0;

        // single requester: grant follows request, locking still applies
        next_cycle();
        req1 = 1'b1;
        unl1 = 1'b0;
        #1;
        check("n1_valid", 0, 32'(gv1), 32'd1);
        check("n1_onehot", 0, 32'(oh1), 32'd1);
        check("n1_index", 0, 32'(idx1), 32'd0);
        check("n1_locked", 0, 32'(lck1), 32'd0);
        next_cycle();
        unl1 = 1'b1;
        #1;
        check("n1_valid", 1, 32'(gv1), 32'd1);
        check("n1_locked", 1, 32'(lck1), 32'd1);
        next_cycle();
        req1 = 1'b0;
        unl1 = 1'b0;
        #1;
        check("n1_valid", 2, 32'(gv1), 32'd0);
        check("n1_onehot", 2, 32'(oh1), 32'd0);
        check("n1_locked", 2, 32'(lck1), 32'd0);

        next_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
